// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// Program-counter sequencer for the fetch front end. Each cycle it decides
// whether the PC advances by one fetch group, holds, or loads a redirect
// target. A commit-stage flush wins over a decode-stage redirect, which wins
// over a normal issue. Fetch is throttled against fetch-queue occupancy, and
// a fetch epoch lets downstream stages discard groups issued before a redirect.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   reset               synchronous active-high reset
//   rob_flush_valid     commit-stage flush (mispredict or trap)
//   rob_flush_addr      commit flush target
//   dec_redirect_valid  decode-stage redirect (predicted-taken jump)
//   dec_redirect_addr   decode redirect target
//   dec_redirect_epoch  epoch of the redirecting group
//   fq_pop              decode consumed one group from the fetch queue
//   icache_ready        I-cache accepts a fetch request this cycle
//   fetch_valid         fetch request for the current PC
//   fetch_epoch         epoch attached to issued groups
//   hold_pc             PC must not advance
//   redirect_enable     PC loads redirect_addr at the next edge
//   redirect_addr       redirect target
//   frontend_flush      squash the fetch queue and in-flight I-cache responses
module fetch_redirect_ctrl #(
  parameter int unsigned CORE_WIDTH   = 2,
  parameter int unsigned INSN_BYTES   = 4,
  parameter int unsigned FQ_DEPTH     = 8,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned EPOCH_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rob_flush_valid,
  input  logic [31:0]           rob_flush_addr,
  input  logic                  dec_redirect_valid,
  input  logic [31:0]           dec_redirect_addr,
  input  logic [EPOCH_BITS-1:0] dec_redirect_epoch,
  input  logic                  fq_pop,
  input  logic                  icache_ready,
  output logic                  fetch_valid,
  output logic [EPOCH_BITS-1:0] fetch_epoch,
  output logic                  hold_pc,
  output logic                  redirect_enable,
  output logic [31:0]           redirect_addr,
  output logic                  frontend_flush
);

  // Occupancy needs one extra bit so that a completely full queue is representable.
  localparam int unsigned OCC_W       = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned FCNT_W      = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned FETCH_BYTES = CORE_WIDTH * INSN_BYTES;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Elaboration-time parameter sanity checks.
  if (FETCH_BYTES == 0) begin : g_bad_group
    $error("fetch_redirect_ctrl: fetch group must be at least one byte");
  end
  if ((FQ_DEPTH < 2) || ((FQ_DEPTH & (FQ_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_redirect_ctrl: FQ_DEPTH must be a power of two >= 2");
  end
  if (FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("fetch_redirect_ctrl: FLUSH_CYCLES must be >= 1");
  end

  logic [0:0]            state_q, state_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;

  logic in_run;
  logic occ_full;
  logic rob_take;
  logic dec_take;
  logic issue;
  logic pop_eff;

  // Event decode; every event is masked while reset is high so the outputs
  // show their reset values in that cycle regardless of stale state.
  always_comb begin
    in_run   = (state_q == ST_RUN);
    occ_full = (occ_q == OCC_W'(FQ_DEPTH));
    rob_take = !reset && rob_flush_valid;
    // A redirect from a group of an older epoch is stale and dropped silently.
    dec_take = !reset && dec_redirect_valid && in_run && !rob_flush_valid &&
               (dec_redirect_epoch == epoch_q);
    // Full check uses registered occupancy only: a same-cycle pop does not
    // unblock fetch until the following cycle.
    fetch_valid = !reset && in_run && !occ_full && !rob_flush_valid && !dec_take;
    issue       = fetch_valid && icache_ready;
    pop_eff     = in_run && fq_pop && (occ_q != '0);
  end

  // Output decode.
  always_comb begin
    redirect_enable = rob_take || dec_take;
    frontend_flush  = rob_take || dec_take;
    // Idle value tracks the flush address so the mux has one stable default.
    redirect_addr   = dec_take ? dec_redirect_addr : rob_flush_addr;
    hold_pc         = !redirect_enable && !issue;
    fetch_epoch     = reset ? '0 : epoch_q;
  end

  // Next-state logic: commit flush > decode redirect > issue/pop bookkeeping.
  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    fcnt_d  = fcnt_q;
    epoch_d = epoch_q;

    if (rob_flush_valid) begin
      // Also restarts the dead-cycle count if already flushing.
      epoch_d = epoch_q + EPOCH_BITS'(1);
      occ_d   = '0;
      fcnt_d  = FCNT_W'(FLUSH_CYCLES);
      state_d = ST_FLUSH;
    end else if (dec_take) begin
      epoch_d = epoch_q + EPOCH_BITS'(1);
      occ_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // Issue only happens below FQ_DEPTH, so this cannot overflow.
          occ_d = occ_q + OCC_W'(issue) - OCC_W'(pop_eff);
        end
        ST_FLUSH: begin
          fcnt_d = fcnt_q - FCNT_W'(1);
          if (fcnt_q == FCNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      occ_q   <= '0;
      fcnt_q  <= '0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      fcnt_q  <= fcnt_d;
      epoch_q <= epoch_d;
    end
  end

endmodule
